// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - stage encoding shared with the transmitter, plus counter sizing helper
package uart_receiver_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } stage_t;

   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous RX pin
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive path with valid/ready word output
// Optional even-parity stage enabled by defining UART_RX_PARITY_EN.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int Word_Len  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                Uart_Rx,
   output logic [Word_Len-1:0] rx_data_out,
   output logic                rx_data_valid,
   input  logic                rx_data_ready,
   output logic                rx_frame_error,
   output logic                rx_overrun,
   output logic                rx_parity_error,
   output logic [2:0]          current_state_out,
   output logic [5:0]          bit_counter_out
);

   localparam int Baud_Rate_Max = CLK_FREQ / BAUD_RATE;
   localparam int Half_Bit      = Baud_Rate_Max / 2;
   localparam int CNT_W         = cnt_width(Baud_Rate_Max);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Half_Bit - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(Baud_Rate_Max - 1);
   localparam logic [5:0]       WORD_LAST = 6'(Word_Len - 1);
`ifdef UART_RX_PARITY_EN
   localparam stage_t AFTER_DATA = PARITY;
`else
   localparam stage_t AFTER_DATA = STOP;
`endif

   stage_t              state, next_state;
   logic                rx_s;
   logic [CNT_W-1:0]    baud_cnt;
   logic [5:0]          bit_cnt;
   logic [Word_Len-1:0] shreg;
   logic [Word_Len:0]   shift_ext;
   logic                half_tick, bit_tick, shift_en, stop_sample, word_bad, word_ok;
`ifdef UART_RX_PARITY_EN
   logic                par_bit;
`endif

   uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (Uart_Rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!rx_s) next_state = START;
         START:   if (half_tick) next_state = rx_s ? IDLE : DATA;
         DATA:    if (shift_en && bit_cnt == WORD_LAST) next_state = AFTER_DATA;
         PARITY:  if (bit_tick) next_state = STOP;
         STOP:    if (bit_tick) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      half_tick   = (baud_cnt == HALF_LAST);
      bit_tick    = (baud_cnt == BIT_LAST);
      shift_en    = (state == DATA) && bit_tick;
      stop_sample = (state == STOP) && bit_tick;
`ifdef UART_RX_PARITY_EN
      word_bad    = ^{shreg, par_bit};
`else
      word_bad    = 1'b0;
`endif
      word_ok     = stop_sample && rx_s && !word_bad;
      shift_ext   = {rx_s, shreg};
   end

   // Restarting on each bit tick keeps the sample point centred bit after bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                baud_cnt <= '0;
      else if ((next_state != state) || bit_tick) baud_cnt <= '0;
      else                                      baud_cnt <= baud_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg          <= '0;
         bit_cnt        <= '0;
         rx_data_out    <= '0;
         rx_data_valid  <= 1'b0;
         rx_frame_error <= 1'b0;
         rx_overrun     <= 1'b0;
      end else begin
         rx_frame_error <= stop_sample && !rx_s;
         rx_overrun     <= word_ok && rx_data_valid && !rx_data_ready;
         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 6'd1;
            shreg   <= shift_ext[Word_Len:1];
         end
         // A word landing on the accepting edge replaces the old one without a gap in valid.
         if (word_ok && (!rx_data_valid || rx_data_ready)) begin
            rx_data_out   <= shreg;
            rx_data_valid <= 1'b1;
         end else if (rx_data_valid && rx_data_ready) begin
            rx_data_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_bit         <= 1'b0;
         rx_parity_error <= 1'b0;
      end else begin
         if ((state == PARITY) && bit_tick) par_bit <= rx_s;
         rx_parity_error <= stop_sample && word_bad;
      end
   end
`else
   assign rx_parity_error = 1'b0;
`endif

   assign current_state_out = state;
   assign bit_counter_out   = bit_cnt;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver at 16 clocks per bit
module tb_uart_receiver;

   localparam int CLK_FREQ  = 1600;
   localparam int BAUD_RATE = 100;
   localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rx_data_ready = 1'b1;
   logic [7:0] rx_data_out;
   logic       rx_data_valid, rx_frame_error, rx_overrun, rx_parity_error;
   logic [2:0] current_state_out;
   logic [5:0] bit_counter_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .Word_Len(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .Uart_Rx           (uart_rx),
      .rx_data_out       (rx_data_out),
      .rx_data_valid     (rx_data_valid),
      .rx_data_ready     (rx_data_ready),
      .rx_frame_error    (rx_frame_error),
      .rx_overrun        (rx_overrun),
      .rx_parity_error   (rx_parity_error),
      .current_state_out (current_state_out),
      .bit_counter_out   (bit_counter_out)
   );

   logic [7:0] got_q[$];
   int cyc = 0, ferr_n = 0, ovr_n = 0, perr_n = 0, start_n = 0, valid_n = 0, valid_rise = 0;
   int fall_cyc = 0;
   logic valid_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data_out);
      if (rx_data_valid && !valid_prev) valid_rise <= cyc;
      valid_prev <= rx_data_valid;
      if (rx_data_valid) valid_n <= valid_n + 1;
      if (rx_frame_error) ferr_n <= ferr_n + 1;
      if (rx_overrun) ovr_n <= ovr_n + 1;
      if (rx_parity_error) perr_n <= perr_n + 1;
      if (current_state_out == 3'd1) start_n <= start_n + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clk);
      #2 uart_rx = b;
      repeat (BIT_CLKS - 1) @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #2 uart_rx = 1'b1;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
      @(posedge clk);
      #2 uart_rx = 1'b0;
      fall_cyc = cyc;
      repeat (BIT_CLKS - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR) drive_bit(par_ok ? ^d : ~^d);
      drive_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par_ok;
      logic       exp_word;
      int         exp_ferr;
      int         exp_perr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic [7:0] d, input logic s, input logic p,
                                   input logic w, input int fe, input int pe);
      vec_t v;
      v = '{data: d, stop: s, par_ok: p, exp_word: w, exp_ferr: fe, exp_perr: pe};
      vecs.push_back(v);
   endfunction

   initial begin
      int f0, o0, p0, s0, v0;
      logic [7:0] exp_q[$];
      int exp_ferr, exp_perr;

      // reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_state", current_state_out, 3'd0);
      check("rst_bitcnt", bit_counter_out, 6'd0);
      check("rst_valid", rx_data_valid, 1'b0);
      check("rst_data", rx_data_out, 8'h00);
      check("rst_flags", {rx_frame_error, rx_overrun, rx_parity_error}, 3'b000);
      reset = 1'b0;
      idle(5);

      // single frame latency and one-cycle valid with ready held
      got_q.delete();
      f0 = ferr_n; o0 = ovr_n; p0 = perr_n; v0 = valid_n;
      send_frame(8'hA5, 1'b1, 1'b1);
      idle(4);
      check("a5_count", got_q.size(), 1);
      if (got_q.size() > 0) check("a5_data", got_q[0], 8'hA5);
      check("a5_latency_ok", (valid_rise - fall_cyc >= 154) && (valid_rise - fall_cyc <= 156), 1'b1);
      check("a5_valid_cycles", valid_n - v0, 1);
      check("a5_flags", (ferr_n - f0) + (ovr_n - o0) + (perr_n - p0), 0);

      // table of single frames
      add_vec(8'h3C, 1'b0, 1'b1, 1'b0, 1, 0);
      add_vec(8'h3D, 1'b1, 1'b1, 1'b1, 0, 0);
      add_vec(8'h00, 1'b1, 1'b1, 1'b1, 0, 0);
      add_vec(8'hFF, 1'b1, 1'b1, 1'b1, 0, 0);
      add_vec(8'h80, 1'b1, 1'b1, 1'b1, 0, 0);
      add_vec(8'h01, 1'b1, 1'b1, 1'b1, 0, 0);
      if (PAR) begin
         add_vec(8'h07, 1'b1, 1'b0, 1'b0, 0, 1);
         add_vec(8'h07, 1'b1, 1'b1, 1'b1, 0, 0);
      end
      for (int k = 0; k < vecs.size(); k++) begin
         got_q.delete();
         f0 = ferr_n; p0 = perr_n;
         send_frame(vecs[k].data, vecs[k].stop, vecs[k].par_ok);
         idle(24);
         check($sformatf("vec%0d_count", k), got_q.size(), vecs[k].exp_word);
         if (vecs[k].exp_word && got_q.size() > 0)
            check($sformatf("vec%0d_data", k), got_q[0], vecs[k].data);
         check($sformatf("vec%0d_ferr", k), ferr_n - f0, vecs[k].exp_ferr);
         check($sformatf("vec%0d_perr", k), perr_n - p0, vecs[k].exp_perr);
         check($sformatf("vec%0d_valid_low", k), rx_data_valid, 1'b0);
      end

      // glitch shorter than half a bit
      got_q.delete();
      f0 = ferr_n; s0 = start_n;
      @(posedge clk);
      #2 uart_rx = 1'b0;
      repeat (3) @(posedge clk);
      #2 uart_rx = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      check("glitch_start_cycles", start_n - s0, 8);
      check("glitch_state", current_state_out, 3'd0);
      check("glitch_no_word", got_q.size(), 0);
      check("glitch_no_ferr", ferr_n - f0, 0);

      // back-to-back frames with consumer stalled
      got_q.delete();
      o0 = ovr_n;
      @(posedge clk);
      #2 rx_data_ready = 1'b0;
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'h02, 1'b1, 1'b1);
      idle(4);
      check("ovr_valid", rx_data_valid, 1'b1);
      check("ovr_data_kept", rx_data_out, 8'h01);
      check("ovr_pulses", ovr_n - o0, 1);
      check("ovr_no_accept", got_q.size(), 0);
      @(posedge clk);
      #2 rx_data_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ovr_valid_drop", rx_data_valid, 1'b0);
      check("ovr_accept_count", got_q.size(), 1);
      if (got_q.size() > 0) check("ovr_accept_data", got_q[0], 8'h01);

      // reset in the middle of data bit 4
      got_q.delete();
      fork
         send_frame(8'hFF, 1'b1, 1'b1);
         begin
            repeat (88) @(posedge clk);
            #3;
            check("pre_rst_bitcnt", bit_counter_out, 6'd4);
            reset = 1'b1;
            #1;
            check("mid_rst_state", current_state_out, 3'd0);
            check("mid_rst_bitcnt", bit_counter_out, 6'd0);
            check("mid_rst_valid", rx_data_valid, 1'b0);
            @(posedge clk);
            #2 reset = 1'b0;
         end
      join
      idle(8);
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      idle(4);
      check("post_rst_no_word", got_q.size(), 0);
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(4);
      check("post_rst_count", got_q.size(), 1);
      if (got_q.size() > 0) check("post_rst_data", got_q[0], 8'h5A);

      // randomized frames against a frame-level model
      got_q.delete();
      exp_q.delete();
      f0 = ferr_n; p0 = perr_n;
      exp_ferr = 0; exp_perr = 0;
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         logic s, p;
         int gap;
         d = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 4) != 0);
         p = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(0, 6);
         send_frame(d, s, p);
         if (s && (p || !PAR)) exp_q.push_back(d);
         if (!s) exp_ferr++;
         if (PAR && !p) exp_perr++;
         if (!s) idle(24);
         else if (gap > 0) idle(gap);
      end
      idle(24);
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("rand_word%0d", i), got_q[i], exp_q[i]);
      check("rand_ferr", ferr_n - f0, exp_ferr);
      check("rand_perr", perr_n - p0, exp_perr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the team's UART. Deserialises an asynchronous 8N1-style line (LSB first) into parallel words.
- Presents each word on a valid/ready handshake to the consumer.
- Pairs with the existing transmitter and shares its CLK_FREQ/BAUD_RATE/Word_Len parameters and stage encoding.
- Sits between the board RX pin and the consumer logic (FIFO or loopback checker).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
Word_Len, 8, data bits per frame (1..32)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
Uart_Rx  input  1  serial line, idle high, asynchronous to clk
rx_data_out  output  Word_Len  received word, stable while rx_data_valid=1
rx_data_valid  output  1  word available; held until accepted
rx_data_ready  input  1  consumer accepts word when valid&ready on a rising edge
rx_frame_error  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: frame completed while previous word unaccepted
rx_parity_error  output  1  one-cycle pulse, parity mismatch (tied 0 without PARITY_EN)
current_state_out  output  3  debug: current state
bit_counter_out  output  6  debug: data bits received in current frame

Behaviour:
- Constants: Baud_Rate_Max = CLK_FREQ/BAUD_RATE (integer division). Half_Bit = Baud_Rate_Max/2.
- Reset (asynchronous assert, applies immediately): state Idle, all counters 0, synchroniser flops 1, rx_data_out 0, all flags 0. Reset mid-frame discards the partial word; the next falling edge starts a fresh frame.
- Input synchronisation: 2-flop synchroniser on Uart_Rx. All decisions use the second flop (rx_s).
- Baud counter: cleared on every state change; otherwise counts up. It is not free-running.
- Idle: rx_s==0 -> Start. Idle is otherwise held.
- Start: when the counter reaches Half_Bit-1, sample rx_s.
  - rx_s==0 -> Data, counter cleared.
  - rx_s==1 -> Idle (glitch rejected, no flags).
- Data: each time the counter reaches Baud_Rate_Max-1, shift rx_s into the MSB of the shift register (right shift, LSB-first line order) and increment Bit_Counter.
  - After the Word_Len-th sample -> Stop (or Parity, see Optional Feature).
- Stop: at Baud_Rate_Max-1, sample rx_s, then go to Idle in the same cycle.
  - rx_s==1 and rx_data_valid==0: load rx_data_out, set rx_data_valid next cycle.
  - rx_s==1, valid==1, ready==1 in the same cycle: load new word, valid stays 1, no overrun.
  - rx_s==1, valid==1, ready==0: keep old word, pulse rx_overrun, discard new word.
  - rx_s==0: pulse rx_frame_error, discard word, valid unchanged.
- Frame completion occurs at mid-stop-bit, so back-to-back frames are received without loss.
- Latency: rx_data_valid rises 2 + Half_Bit + (Word_Len+1)*Baud_Rate_Max cycles after the pin falls, ±1.
- Handshake: valid&ready on an edge deasserts valid, unless a new word loads on that same edge. rx_data_out is undefined-free and holds the last accepted value when valid=0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: an extra Parity state (encoding `Parity = 3'd4`) between Data and Stop. Samples one bit at Baud_Rate_Max-1 and checks even parity (XOR of data and parity bit == 0).
  - Mismatch: pulse rx_parity_error at the Stop sample and discard the word, even if the stop bit is good.
- Undefined: no Parity state; rx_parity_error driven constant 0; latency formula as above.

Decomposition:
- Shared stage header (Stages.vh) holds `Idle`, `Start`, `Data`, `Stop` and adds `Parity`. The transmitter and receiver share it.
- Baud-rate constants are derived locally from parameters.
- One natural sub-module: uart_rx_sync (2-flop synchroniser with reset value parameter). Everything else stays in one module.

Test Plan:
(All use CLK_FREQ=1600, BAUD_RATE=100 -> 16 clocks/bit, Half_Bit=8.)
1. Send 0xA5, ready held 1 -> rx_data_out=0xA5, valid high exactly one cycle, 154..156 cycles after the start edge; no flags.
2. Drive Uart_Rx low for 3 clocks then high -> state returns Idle after 8 Start cycles; no valid, no flags.
3. Send 0x3C with stop bit 0 -> rx_frame_error pulses once; valid stays 0; next frame 0x3D received correctly.
4. Back-to-back 0x01 then 0x02, ready=0 -> valid high with 0x01; rx_overrun pulses at second stop sample; rx_data_out remains 0x01. Raising ready then drops valid.
5. Assert reset during data bit 4 of 0xFF -> immediate Idle, counters 0, no valid; a following 0x5A is received correctly.
6. With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_parity_error pulse, no valid. 0x07 with parity bit 1 -> 0x07 delivered.
